// File: rtl/pu_pkg.sv
// Shared PU definitions: lane geometry and the operand vector type.
// Imported by the PU and by its operand loader.
package pu_pkg;

    localparam int PU_NUM_LANES = 8;
    localparam int PU_DATA_W    = 32;

    typedef logic [PU_NUM_LANES-1:0][PU_DATA_W-1:0] lane_vec_t;

endpackage

// File: rtl/pu_lane_next.sv
// Active-lane walker for the operand loader.
// Finds the next active lane above the current one.
module pu_lane_next #(
    parameter int NUM_LANES = 8
) (
    input  logic [NUM_LANES-1:0]         i_act_msk,
    input  logic [$clog2(NUM_LANES)-1:0] i_lane,
    output logic [$clog2(NUM_LANES)-1:0] o_next,
    output logic                         o_is_last
);

    localparam int LW = $clog2(NUM_LANES);

    // descending scan so the lowest active lane above i_lane wins
    always_comb begin
        o_next    = '0;
        o_is_last = 1'b1;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (i > int'(i_lane) && i_act_msk[i]) begin
                o_next    = LW'(i);
                o_is_last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pu_operand_loader.sv
// Packs a 32-bit word stream into PU operand vectors,
// skipping constant lanes, with a small slot buffer.
module pu_operand_loader
    import pu_pkg::*;
#(
    parameter int NUM_LANES = PU_NUM_LANES,
    parameter int DATA_W    = PU_DATA_W,
    parameter int DEPTH     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_en,
    input  logic                          cfg_flush,
    input  logic [NUM_LANES-1:0]          cfg_lane_msk,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [NUM_LANES*DATA_W-1:0]   pu_data,
    output logic [NUM_LANES-1:0]          pu_dv,
    input  logic                          pu_rdy,
    output logic [$clog2(DEPTH):0]        o_slots_full,
    output logic                          o_partial,
    output logic [15:0]                   o_vec_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(NUM_LANES);
    localparam int CW = PW + 1;

    typedef logic [NUM_LANES-1:0][DATA_W-1:0] slot_t;

    slot_t                r_slot [DEPTH];
    logic [DEPTH-1:0]     r_full;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_lane;
    logic                 r_partial;
    logic [NUM_LANES-1:0] r_act_msk;
    logic [15:0]          r_vec_cnt;

    logic [NUM_LANES-1:0] w_new_msk;
    logic [NUM_LANES-1:0] w_cur_msk;
    logic [LW-1:0]        w_first;
    logic [LW-1:0]        w_lane;
    logic [LW-1:0]        w_next;
    logic                 w_is_last;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_done;
    logic                 w_pop;
    logic [DEPTH-1:0]     w_set;
    logic [DEPTH-1:0]     w_clr;
    logic [CW-1:0]        w_cnt;

    assign w_new_msk = ~cfg_lane_msk;
    assign w_cur_msk = r_partial ? r_act_msk : w_new_msk;

    // lowest active lane of the mask a new vector would latch
    always_comb begin
        w_first = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (w_new_msk[i]) begin
                w_first = LW'(i);
            end
        end
    end

    assign w_lane = r_partial ? r_lane : w_first;

    pu_lane_next #(
        .NUM_LANES (NUM_LANES)
    ) u_lane_next (
        .i_act_msk (w_cur_msk),
        .i_lane    (w_lane),
        .o_next    (w_next),
        .o_is_last (w_is_last)
    );

    assign w_ready  = cfg_en & ~r_full[r_wr_ptr] & ~cfg_flush
                    & (|w_new_msk);
    assign w_accept = w_ready & s_valid;
    assign w_done   = w_accept & w_is_last;
    assign w_pop    = r_full[r_rd_ptr] & pu_rdy;

    // one-hot set/clear of slot full flags; slots are always distinct
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_done) begin
            w_set[r_wr_ptr] = 1'b1;
        end
        if (w_pop) begin
            w_clr[r_rd_ptr] = 1'b1;
        end
    end

    // fill-side state: write pointer, lane walk and latched mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_lane    <= '0;
            r_partial <= 1'b0;
            r_act_msk <= '0;
        end else if (cfg_flush) begin
            r_wr_ptr  <= '0;
            r_lane    <= '0;
            r_partial <= 1'b0;
        end else if (w_accept) begin
            if (!r_partial) begin
                r_act_msk <= w_new_msk;
            end
            if (w_is_last) begin
                r_wr_ptr  <= r_wr_ptr + PW'(1);
                r_lane    <= '0;
                r_partial <= 1'b0;
            end else begin
                r_lane    <= w_next;
                r_partial <= 1'b1;
            end
        end
    end

    // slot data; the first word of a vector zeroes the other lanes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                r_slot[s] <= '0;
            end
        end else if (w_accept) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (LW'(l) == w_lane) begin
                    r_slot[r_wr_ptr][l] <= s_data;
                end else if (!r_partial) begin
                    r_slot[r_wr_ptr][l] <= '0;
                end
            end
        end
    end

    // drain side: full flags and read pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full   <= '0;
            r_rd_ptr <= '0;
        end else if (cfg_flush) begin
            r_full   <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_full <= (r_full | w_set) & ~w_clr;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // delivered vector count survives flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_cnt <= '0;
        end else if (w_pop) begin
            r_vec_cnt <= r_vec_cnt + 16'd1;
        end
    end

    // number of complete slots waiting for the PU
    always_comb begin
        w_cnt = '0;
        for (int s = 0; s < DEPTH; s++) begin
            w_cnt = w_cnt + CW'(r_full[s]);
        end
    end

    assign s_ready      = w_ready;
    assign pu_dv        = {NUM_LANES{r_full[r_rd_ptr]}};
    assign pu_data      = r_slot[r_rd_ptr];
    assign o_slots_full = w_cnt;
    assign o_partial    = r_partial;
    assign o_vec_cnt    = r_vec_cnt;

endmodule
